// File: rtl/pbuf6_pkg.sv
// Shared constants and types for the pbuf6 programmable buffer bank.
package pbuf6_pkg;
  localparam int unsigned NUM_STAGES          = 6;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef logic [NUM_STAGES-1:0] pbuf_cfg_t;
endpackage

// File: rtl/pbuf_edge_sync.sv
// Strobe synchronizer with a rising-edge detector; the synchronizer flops are
// never reset, only the edge-history flop is.
module pbuf_edge_sync
  import pbuf6_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic level,
  output logic pulse
);

  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("pbuf_edge_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // History resets high so a strobe already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
    if (!rst_n) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign pulse = level & ~hist_q;

endmodule

// File: rtl/pbuf6.sv
// Six-lane programmable tri-state buffer bank with a two-phase serial config chain.
// Optional macro PBUF6_OVERLAP_CHECK_EN adds the sticky prog_err overlap flag.
module pbuf6
  import pbuf6_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] in,
  output logic [5:0] out,
  input  logic       prog_in,
  output logic       prog_out,
  input  logic       prog_clk0,
  input  logic       prog_clk1
`ifdef PBUF6_OVERLAP_CHECK_EN
  ,
  output logic       prog_err
`endif
);

  pbuf_cfg_t q;
  logic      lvl0, lvl1;
  logic      ph0, ph1;
  logic      sh0, sh1;

  pbuf_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (prog_clk0),
    .level  (lvl0),
    .pulse  (ph0)
  );

  pbuf_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (prog_clk1),
    .level  (lvl1),
    .pulse  (ph1)
  );

`ifdef PBUF6_OVERLAP_CHECK_EN
  logic overlap;

  // Both synchronized levels high blocks either phase from shifting.
  assign overlap = lvl0 & lvl1;
  assign sh0     = ph0 & ~overlap;
  assign sh1     = ph1 & ~overlap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prog_err <= 1'b0;
    end else if (overlap) begin
      prog_err <= 1'b1;
    end
  end
`else
  logic unused_lvl;

  assign sh0        = ph0;
  assign sh1        = ph1;
  assign unused_lvl = lvl0 ^ lvl1;
`endif

  // Even and odd stages both read pre-edge values, so a coincident pair is safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      if (sh0) begin
        q[0] <= prog_in;
        q[2] <= q[1];
        q[4] <= q[3];
      end
      if (sh1) begin
        q[1] <= q[0];
        q[3] <= q[2];
        q[5] <= q[4];
      end
    end
  end

  assign prog_out = q[5];

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_lane
    assign out[i] = q[i] ? in[i] : 1'bz;
  end

endmodule

// File: tb/tb_pbuf6.sv
// Self-checking bench for pbuf6: table of operations with a scoreboard of
// expected lane/chain outputs; disabled lanes are read through pulldowns as 0.
module tb_pbuf6;
  import pbuf6_pkg::*;

  localparam int unsigned SYNC = DEFAULT_SYNC_STAGES;
  localparam int unsigned HOLD = SYNC + 2;

  typedef enum {OP_RST, OP_NONE, OP_PH0, OP_PH1, OP_PAIR, OP_BOTH} op_e;

  typedef struct {
    op_e        op;
    logic       pin;
    logic [5:0] din;
    logic [5:0] exp_q;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [5:0] out;
    logic       pout;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] in;
  logic       prog_in;
  logic       prog_out;
  logic       prog_clk0;
  logic       prog_clk1;
  wire  [5:0] out_w;
`ifdef PBUF6_OVERLAP_CHECK_EN
  logic       prog_err;
`endif

  always #5 clk = ~clk;

  for (genvar i = 0; i < 6; i++) begin : g_pd
    pulldown (out_w[i]);
  end

  pbuf6 #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out       (out_w),
    .prog_in   (prog_in),
    .prog_out  (prog_out),
    .prog_clk0 (prog_clk0),
    .prog_clk1 (prog_clk1)
`ifdef PBUF6_OVERLAP_CHECK_EN
    ,
    .prog_err  (prog_err)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[18];

  task automatic cmp(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic s0, input logic s1);
    prog_clk0 = s0;
    prog_clk1 = s1;
    idle(HOLD);
    prog_clk0 = 1'b0;
    prog_clk1 = 1'b0;
    idle(HOLD);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic expect_q(input logic [5:0] din, input logic [5:0] q_exp, input logic err_exp);
    exp_t e;
    e.out  = din & q_exp;
    e.pout = q_exp[5];
    e.err  = err_exp;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    cmp({name, ".out"}, out_w, e.out);
    cmp({name, ".prog_out"}, {5'b0, prog_out}, {5'b0, e.pout});
`ifdef PBUF6_OVERLAP_CHECK_EN
    cmp({name, ".prog_err"}, {5'b0, prog_err}, {5'b0, e.err});
`endif
  endtask

  initial begin
`ifdef PBUF6_OVERLAP_CHECK_EN
    localparam logic [5:0] BOTH_Q   = 6'b000001;
    localparam logic       BOTH_ERR = 1'b1;
`else
    localparam logic [5:0] BOTH_Q   = 6'b000010;
    localparam logic       BOTH_ERR = 1'b0;
`endif
    tbl[0]  = '{OP_RST,  1'b0, 6'b000000, 6'b000000, 1'b0};
    tbl[1]  = '{OP_NONE, 1'b0, 6'b111111, 6'b000000, 1'b0};
    tbl[2]  = '{OP_PAIR, 1'b1, 6'b101010, 6'b000011, 1'b0};
    tbl[3]  = '{OP_PAIR, 1'b1, 6'b101010, 6'b001111, 1'b0};
    tbl[4]  = '{OP_PAIR, 1'b1, 6'b101010, 6'b111111, 1'b0};
    tbl[5]  = '{OP_NONE, 1'b0, 6'b010101, 6'b111111, 1'b0};
    tbl[6]  = '{OP_RST,  1'b0, 6'b111111, 6'b000000, 1'b0};
    tbl[7]  = '{OP_PAIR, 1'b1, 6'b111111, 6'b000011, 1'b0};
    tbl[8]  = '{OP_PAIR, 1'b0, 6'b111111, 6'b001100, 1'b0};
    tbl[9]  = '{OP_PAIR, 1'b0, 6'b111111, 6'b110000, 1'b0};
    tbl[10] = '{OP_NONE, 1'b0, 6'b101101, 6'b110000, 1'b0};
    tbl[11] = '{OP_RST,  1'b0, 6'b111111, 6'b000000, 1'b0};
    tbl[12] = '{OP_PH0,  1'b1, 6'b111111, 6'b000001, 1'b0};
    tbl[13] = '{OP_PH1,  1'b0, 6'b111111, 6'b000011, 1'b0};
    tbl[14] = '{OP_PAIR, 1'b1, 6'b111111, 6'b001111, 1'b0};
    tbl[15] = '{OP_PH0,  1'b1, 6'b111111, 6'b000001, 1'b0};
    tbl[16] = '{OP_BOTH, 1'b0, 6'b111111, BOTH_Q,    BOTH_ERR};
    tbl[17] = '{OP_RST,  1'b0, 6'b111111, 6'b000000, 1'b0};

    rst_n     = 1'b0;
    in        = '0;
    prog_in   = 1'b0;
    prog_clk0 = 1'b0;
    prog_clk1 = 1'b0;
    idle(SYNC + 2);

    for (int k = 0; k < 18; k++) begin
      in      = tbl[k].din;
      prog_in = tbl[k].pin;
      case (tbl[k].op)
        OP_RST:  do_reset();
        OP_NONE: idle(1);
        OP_PH0:  strobe(1'b1, 1'b0);
        OP_PH1:  strobe(1'b0, 1'b1);
        OP_PAIR: begin strobe(1'b1, 1'b0); strobe(1'b0, 1'b1); end
        OP_BOTH: strobe(1'b1, 1'b1);
        default: idle(1);
      endcase
      expect_q(tbl[k].din, tbl[k].exp_q, tbl[k].exp_err);
      check_sb($sformatf("row%0d", k));

      // After loading 001111, reset with prog_clk0 held high across release.
      if (k == 14) begin
        in        = 6'b111111;
        prog_in   = 1'b1;
        rst_n     = 1'b0;
        prog_clk0 = 1'b1;
        idle(1);
        expect_q(in, 6'b000000, 1'b0);
        check_sb("midload_rst");
        idle(3);
        rst_n = 1'b1;
        idle(HOLD + 2);
        expect_q(in, 6'b000000, 1'b0);
        check_sb("held_strobe");
        prog_clk0 = 1'b0;
        idle(HOLD);
        expect_q(in, 6'b000000, 1'b0);
        check_sb("strobe_drop");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
